// File: rtl/paula_floppy_wr_serializer.sv
// Paula floppy write-side serializer.
// Drains 16-bit MFM words from the floppy word FIFO and shifts them out MSB-first as a
// gapless serial bit-cell stream. The next word is prefetched into a hold register while
// the current one shifts. Everything advances only on clk7_en ticks (E-ticks).
//
// Ports:
//   clk, reset      bus clock, synchronous active-high reset (not gated by clk7_en)
//   clk7_en_i       E-tick enable
//   start_i         begin a transfer of len_i words (accepted in idle only)
//   abort_i         terminate the active transfer on the next E-tick
//   len_i           number of words to write, latched at start
//   fifo_q_i        FIFO data, valid on the E-tick after a fifo_rd_o tick
//   fifo_empty_i    FIFO empty flag
//   fifo_rd_o       FIFO read request, one E-tick per word
//   wr_bit_o        current cell data bit
//   wr_strobe_o     high on the first E-tick of each cell
//   wr_gate_o       drive write gate, high while cells are emitted
//   busy_o          transfer in progress
//   done_o          one-E-tick pulse on any termination
//   underrun_o      sticky underrun flag, cleared by the next accepted start
module paula_floppy_wr_serializer #(
   parameter int unsigned CELL_DIV = 14,
   parameter int unsigned LEN_W    = 14
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clk7_en_i,
   input  logic             start_i,
   input  logic             abort_i,
   input  logic [LEN_W-1:0] len_i,
   input  logic [15:0]      fifo_q_i,
   input  logic             fifo_empty_i,
   output logic             fifo_rd_o,
   output logic             wr_bit_o,
   output logic             wr_strobe_o,
   output logic             wr_gate_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             underrun_o
);

   typedef enum logic [2:0] {StIdle, StPrime, StLoad, StShift, StDone} state_e;

   state_e           state_q, state_d;
   logic [LEN_W-1:0] rem_fetch_q, rem_fetch_d;
   logic [LEN_W-1:0] rem_shift_q, rem_shift_d;
   logic [7:0]       cell_cnt_q, cell_cnt_d;
   logic [3:0]       bit_cnt_q, bit_cnt_d;
   logic [15:0]      shift_q, shift_d;
   logic [15:0]      hold_q, hold_d;
   logic             hold_vld_q, hold_vld_d;
   logic             rd_pend_q, rd_pend_d;
   logic             underrun_q, underrun_d;

   logic cell_last;
   logic word_end;

   assign cell_last = (cell_cnt_q == 8'(CELL_DIV - 1));
   assign word_end  = cell_last && (bit_cnt_q == 4'd15);

   always_comb begin
      state_d     = state_q;
      rem_fetch_d = rem_fetch_q;
      rem_shift_d = rem_shift_q;
      cell_cnt_d  = cell_cnt_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      hold_d      = hold_q;
      hold_vld_d  = hold_vld_q;
      rd_pend_d   = rd_pend_q;
      underrun_d  = underrun_q;
      fifo_rd_o   = 1'b0;

      if (clk7_en_i) begin
         // A prefetch read issued last E-tick delivers its word now. Outside SHIFT the
         // word belongs to an aborted transfer and is dropped.
         if (rd_pend_q) begin
            rd_pend_d = 1'b0;
            if (state_q == StShift) begin
               hold_d     = fifo_q_i;
               hold_vld_d = 1'b1;
            end
         end

         unique case (state_q)
            StIdle: begin
               hold_vld_d = 1'b0;
               if (start_i) begin
                  underrun_d = 1'b0;
                  if (len_i == '0) begin
                     state_d = StDone;
                  end else begin
                     rem_fetch_d = len_i;
                     rem_shift_d = len_i;
                     state_d     = StPrime;
                  end
               end
            end

            StPrime: begin
               if (abort_i) begin
                  state_d = StDone;
               end else if (!fifo_empty_i) begin
                  fifo_rd_o   = 1'b1;
                  rem_fetch_d = rem_fetch_q - LEN_W'(1);
                  state_d     = StLoad;
               end
            end

            StLoad: begin
               if (abort_i) begin
                  state_d = StDone;
               end else begin
                  shift_d    = fifo_q_i;
                  cell_cnt_d = 8'd0;
                  bit_cnt_d  = 4'd0;
                  state_d    = StShift;
               end
            end

            StShift: begin
               if (abort_i) begin
                  state_d = StDone;
               end else begin
                  if (cell_last) begin
                     cell_cnt_d = 8'd0;
                     shift_d    = {shift_q[14:0], 1'b0};
                     bit_cnt_d  = bit_cnt_q + 4'd1;
                  end else begin
                     cell_cnt_d = cell_cnt_q + 8'd1;
                  end

                  if (word_end) begin
                     rem_shift_d = rem_shift_q - LEN_W'(1);
                     if (rem_shift_q == LEN_W'(1)) begin
                        state_d = StDone;
                     end else if (hold_vld_q) begin
                        // Back-to-back word: next cell starts on the next E-tick.
                        shift_d    = hold_q;
                        hold_vld_d = 1'b0;
                        cell_cnt_d = 8'd0;
                        bit_cnt_d  = 4'd0;
                     end else begin
                        underrun_d = 1'b1;
                        state_d    = StDone;
                     end
                  end else if (!hold_vld_q && (rem_fetch_q != '0) && !fifo_empty_i &&
                               !rd_pend_q) begin
                     fifo_rd_o   = 1'b1;
                     rem_fetch_d = rem_fetch_q - LEN_W'(1);
                     rd_pend_d   = 1'b1;
                  end
               end
            end

            StDone: begin
               hold_vld_d = 1'b0;
               rd_pend_d  = 1'b0;
               state_d    = StIdle;
            end

            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         rem_fetch_q <= '0;
         rem_shift_q <= '0;
         cell_cnt_q  <= 8'd0;
         bit_cnt_q   <= 4'd0;
         shift_q     <= 16'd0;
         hold_q      <= 16'd0;
         hold_vld_q  <= 1'b0;
         rd_pend_q   <= 1'b0;
         underrun_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         rem_fetch_q <= rem_fetch_d;
         rem_shift_q <= rem_shift_d;
         cell_cnt_q  <= cell_cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         hold_q      <= hold_d;
         hold_vld_q  <= hold_vld_d;
         rd_pend_q   <= rd_pend_d;
         underrun_q  <= underrun_d;
      end
   end

   assign wr_gate_o   = (state_q == StShift);
   assign wr_strobe_o = wr_gate_o && (cell_cnt_q == 8'd0);
   assign wr_bit_o    = wr_gate_o && shift_q[15];
   assign busy_o      = (state_q != StIdle);
   assign done_o      = clk7_en_i && (state_q == StDone);
   assign underrun_o  = underrun_q;

endmodule

// File: tb/tb_paula_floppy_wr_serializer.sv
// Self-checking bench for paula_floppy_wr_serializer: a FIFO model feeds the DUT, a
// monitor records the serial stream, and each transfer is compared with the words,
// counts and cell timing expected from the loaded data.
module tb_paula_floppy_wr_serializer;

   localparam int unsigned CellDiv = 14;
   localparam int unsigned LenW    = 14;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            clk7_en = 1'b0;
   logic            start = 1'b0;
   logic            abort = 1'b0;
   logic [LenW-1:0] len = '0;
   logic [15:0]     fifo_q = 16'd0;
   logic            fifo_empty;
   logic            fifo_rd, wr_bit, wr_strobe, wr_gate, busy, done, underrun;

   always #5 clk = ~clk;

   paula_floppy_wr_serializer #(
      .CELL_DIV(CellDiv),
      .LEN_W   (LenW)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .clk7_en_i   (clk7_en),
      .start_i     (start),
      .abort_i     (abort),
      .len_i       (len),
      .fifo_q_i    (fifo_q),
      .fifo_empty_i(fifo_empty),
      .fifo_rd_o   (fifo_rd),
      .wr_bit_o    (wr_bit),
      .wr_strobe_o (wr_strobe),
      .wr_gate_o   (wr_gate),
      .busy_o      (busy),
      .done_o      (done),
      .underrun_o  (underrun)
   );

   // FIFO model: data appears after the E-tick that reads it.
   logic [15:0] mem [256];
   logic [7:0]  rd_ptr = 8'd0;
   logic [7:0]  wr_ptr = 8'd0;
   assign fifo_empty = (rd_ptr == wr_ptr);

   always @(posedge clk) begin
      if (clk7_en && fifo_rd) begin
         fifo_q <= mem[rd_ptr];
         rd_ptr <= rd_ptr + 8'd1;
      end
   end

   // Monitor, sampled on the falling edge.
   int etick_cnt = 0, cyc_cnt = 0, rd_cnt = 0, rd_gate_cnt = 0, done_cnt = 0;
   int gate_cnt = 0, bad_pulse = 0;
   bit bits_q[$];
   int strobe_tick_q[$];
   int strobe_cyc_q[$];

   always @(negedge clk) begin
      cyc_cnt++;
      if (clk7_en) begin
         etick_cnt++;
         if (fifo_rd) rd_cnt++;
         if (fifo_rd && wr_gate) rd_gate_cnt++;
         if (done) done_cnt++;
         if (wr_gate) gate_cnt++;
         if (wr_strobe) begin
            bits_q.push_back(wr_bit);
            strobe_tick_q.push_back(etick_cnt);
            strobe_cyc_q.push_back(cyc_cnt);
         end
      end else if (fifo_rd || done) begin
         bad_pulse++;
      end
   end

   int n_checks = 0, n_errors = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   int          en_mode = 0;
   int          phase = 0;
   logic [15:0] words [4];

   task automatic tick();
      @(posedge clk);
      #1;
      phase++;
      case (en_mode)
         0:       clk7_en = 1'b1;
         1:       clk7_en = ((phase % 4) == 0);
         default: clk7_en = 1'($urandom_range(0, 1));
      endcase
   endtask

   task automatic send_start(input logic [LenW-1:0] l);
      logic was;
      start = 1'b1;
      len   = l;
      do begin
         was = clk7_en;
         tick();
      end while (!was);
      start = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (busy && n < 20000) begin
         tick();
         n++;
      end
      check_eq({tag, "_idle_timeout"}, 64'(n >= 20000), 64'd0);
   endtask

   task automatic push_words(input int n);
      for (int i = 0; i < n; i++) begin
         mem[wr_ptr] = words[i];
         wr_ptr = wr_ptr + 8'd1;
      end
   endtask

   // Full transfer of l words with `avail` words preloaded from words[].
   task automatic run_xfer(input string tag, input int l, input int avail);
      int          r0, rg0, g0, d0, bp0, q0, nw, bad_gap;
      logic [63:0] eb, gb;
      r0  = rd_cnt;
      rg0 = rd_gate_cnt;
      g0  = gate_cnt;
      d0  = done_cnt;
      bp0 = bad_pulse;
      q0  = bits_q.size();
      push_words(avail);
      send_start(LenW'(l));
      wait_idle(tag);
      nw = (avail < l) ? avail : l;
      eb = 64'd0;
      gb = 64'd0;
      for (int w = 0; w < nw; w++) eb = {eb[47:0], words[w]};
      for (int i = q0; i < bits_q.size(); i++) gb = {gb[62:0], bits_q[i]};
      bad_gap = 0;
      for (int i = q0 + 1; i < strobe_tick_q.size(); i++)
         if (strobe_tick_q[i] - strobe_tick_q[i-1] != int'(CellDiv)) bad_gap++;
      check_eq({tag, "_rd"}, 64'(rd_cnt - r0), 64'(nw));
      check_eq({tag, "_rd_prefetch"}, 64'(rd_gate_cnt - rg0), 64'(nw - 1));
      check_eq({tag, "_gate_ticks"}, 64'(gate_cnt - g0), 64'(nw * 16 * int'(CellDiv)));
      check_eq({tag, "_cells"}, 64'(bits_q.size() - q0), 64'(nw * 16));
      check_eq({tag, "_bits"}, gb, eb);
      check_eq({tag, "_cell_gaps"}, 64'(bad_gap), 64'd0);
      check_eq({tag, "_done"}, 64'(done_cnt - d0), 64'd1);
      check_eq({tag, "_underrun"}, 64'(underrun), 64'(avail < l));
      check_eq({tag, "_gated_pulses"}, 64'(bad_pulse - bp0), 64'd0);
      wr_ptr = rd_ptr;
   endtask

   // Starts len=4 and runs until cell 5 of word 2 is 3 E-ticks in.
   task automatic start_and_reach_word2(input string tag);
      int n = 0;
      for (int i = 0; i < 4; i++) words[i] = 16'($urandom);
      push_words(4);
      send_start(LenW'(4));
      while (!wr_gate && n < 1000) begin
         tick();
         n++;
      end
      check_eq({tag, "_gate_timeout"}, 64'(n >= 1000), 64'd0);
      repeat (21 * CellDiv + 3) tick();
   endtask

   initial begin
      int r0, g0, d0, s0, l, avail, bad_cyc;

      // Reset state.
      en_mode = 0;
      repeat (3) tick();
      check_eq("reset_outputs",
               64'({fifo_rd, wr_bit, wr_strobe, wr_gate, busy, done, underrun}), 64'd0);
      reset = 1'b0;
      tick();

      // Single word, cell pattern 1010 0101 1111 0000.
      words[0] = 16'hA5F0;
      run_xfer("one_word", 1, 1);

      // Three prefetched words, contiguous cells.
      words[0] = 16'hFFFF;
      words[1] = 16'h0000;
      words[2] = 16'hAAAA;
      run_xfer("three_words", 3, 3);

      // Underrun: only one of two words available.
      words[0] = 16'h4489;
      run_xfer("underrun", 2, 1);
      repeat (5) tick();
      check_eq("underrun_sticky", 64'(underrun), 64'd1);
      check_eq("underrun_idle", 64'(busy), 64'd0);

      // Zero-length transfer: done one E-tick after start, no reads, no gate.
      r0 = rd_cnt;
      g0 = gate_cnt;
      d0 = done_cnt;
      send_start(LenW'(0));
      check_eq("len0_done_now", 64'({done, busy}), 64'b11);
      tick();
      check_eq("len0_idle", 64'(busy), 64'd0);
      check_eq("len0_done_cnt", 64'(done_cnt - d0), 64'd1);
      check_eq("len0_no_rd", 64'(rd_cnt - r0), 64'd0);
      check_eq("len0_no_gate", 64'(gate_cnt - g0), 64'd0);

      // Abort in cell 5 of word 2.
      r0 = rd_cnt;
      g0 = gate_cnt;
      d0 = done_cnt;
      s0 = bits_q.size();
      start_and_reach_word2("abort");
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check_eq("abort_gate_done", 64'({wr_gate, done, busy}), 64'b011);
      tick();
      check_eq("abort_idle", 64'(busy), 64'd0);
      check_eq("abort_gate_ticks", 64'(gate_cnt - g0), 64'(21 * CellDiv + 4));
      check_eq("abort_cells", 64'(bits_q.size() - s0), 64'd22);
      check_eq("abort_rd", 64'(rd_cnt - r0), 64'd3);
      check_eq("abort_done", 64'(done_cnt - d0), 64'd1);
      check_eq("abort_underrun", 64'(underrun), 64'd0);
      wr_ptr = rd_ptr;

      // Same point, reset instead of abort.
      start_and_reach_word2("rst");
      d0 = done_cnt;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_eq("rst_outputs",
               64'({fifo_rd, wr_bit, wr_strobe, wr_gate, busy, done, underrun}), 64'd0);
      repeat (4) tick();
      check_eq("rst_no_done", 64'(done_cnt - d0), 64'd0);
      check_eq("rst_still_idle", 64'(busy), 64'd0);
      wr_ptr = rd_ptr;

      // 1-of-4 E-tick enable: 56 clocks per cell.
      en_mode = 1;
      words[0] = 16'hA5F0;
      s0 = strobe_cyc_q.size();
      run_xfer("slow_en", 1, 1);
      bad_cyc = 0;
      for (int i = s0 + 1; i < strobe_cyc_q.size(); i++)
         if (strobe_cyc_q[i] - strobe_cyc_q[i-1] != 4 * int'(CellDiv)) bad_cyc++;
      check_eq("slow_en_cell_clks", 64'(bad_cyc), 64'd0);

      // Randomized transfers, occasionally short of data.
      for (int it = 0; it < 10; it++) begin
         en_mode = int'($urandom_range(0, 2));
         l = int'($urandom_range(1, 4));
         avail = l;
         if (l > 1 && $urandom_range(0, 3) == 0) avail = int'($urandom_range(1, l - 1));
         for (int i = 0; i < 4; i++) words[i] = 16'($urandom);
         run_xfer($sformatf("rand%0d", it), l, avail);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
